mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore-style FSM that sequences a multicycle MIPS datapath: shared memory, IR, register bank, ALU and PC mux.
//  Decodes opcode[5:0] and emits per-state control strobes.
//  Stalls on a memory-ready handshake.
//  Counts retired instructions and flags illegal opcodes.
//  Sits beside the mips top level and replaces its single-cycle control decode.
// PARAMETERS
//  CNT_W      32  width of the retired-instruction counter
//  TRAP_EN    1   1: illegal opcode pulses illegal_op and restarts fetch; 0: illegal opcode treated as NOP, same path, no pulse
// PORTS
//  clock          in   1      rising-edge system clock
//  reset_n        in   1      asynchronous active-low reset
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  mem_ready      in   1      memory access completes this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero (datapath ANDs with zero)
//  iord           out  1      0: address=PC, 1: address=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      IR load
//  mem_to_reg     out  1      write-back data: 1=MDR, 0=ALUOut
//  reg_dst        out  1      write-back register: 1=rd, 0=rt
//  reg_write      out  1      register bank write enable
//  alu_src_a      out  1      0=PC, 1=A register
//  alu_src_b      out  2      0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2
//  alu_op         out  2      0=add, 1=sub, 2=funct field, 3=reserved
//  pc_source      out  2      0=ALU result, 1=ALUOut, 2=jump target
//  illegal_op     out  1      one-cycle pulse on an unsupported opcode
//  instr_retired  out  CNT_W  retired-instruction count
//  state_dbg      out  4      current state encoding
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=RST; all outputs 0; instr_retired=0; illegal_op=0.
//   - Reset mid-instruction aborts it immediately; no further strobes.
//  State transitions (one state per clock):
//   - RST -> FETCH unconditionally on the first edge after release.
//   - FETCH: mem_read=1, iord=0, src_a=0, src_b=1, alu_op=0.
//     - ir_write and pc_write asserted only while mem_ready=1.
//     - Exit to DECODE on mem_ready=1; otherwise hold.
//   - DECODE: src_a=0, src_b=3, alu_op=0 (branch target precompute). Next state by opcode:
//     - 000000 (R)            -> EXEC
//     - 100011 (lw), 101011 (sw) -> MEMADR
//     - 000100 (beq)          -> BRANCH
//     - 001000 (addi)         -> ADDIEX
//     - 000010 (j)            -> JUMP
//     - anything else         -> FETCH, illegal_op pulse (TRAP_EN=1)
//   - MEMADR: src_a=1, src_b=2, alu_op=0 -> MEMRD (lw) or MEMWR (sw).
//   - MEMRD: mem_read=1, iord=1; -> MEMWB on mem_ready; otherwise hold.
//   - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//   - MEMWR: mem_write=1, iord=1; -> FETCH on mem_ready; otherwise hold (write stays asserted).
//   - EXEC: src_a=1, src_b=0, alu_op=2 -> ALUWB.
//   - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//   - ADDIEX: src_a=1, src_b=2, alu_op=0 -> ADDIWB.
//   - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//   - BRANCH: src_a=1, src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 -> FETCH.
//   - JUMP: pc_write=1, pc_source=2 -> FETCH.
//  Outputs:
//   - Unlisted outputs are 0 in every state.
//   - Strobes are combinational from state, plus mem_ready in FETCH only.
//  instr_retired:
//   - +1 on every edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, ADDIWB, BRANCH or JUMP.
//   - Wraps 2^CNT_W-1 -> 0.
//   - Illegal opcodes are not counted.
//  illegal_op:
//   - Registered; high exactly the cycle after DECODE.
//   - Cleared in that cycle by the next edge unless re-asserted.
//  Latencies (cycles, zero wait): R/addi 4, lw 5, sw 4, beq 3, j 3.
//   - Each mem_ready=0 cycle adds one.
//  Unused encodings of state_dbg return to FETCH (safe recovery), illegal_op=0.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode constants, state encoding, alu_op/alu_src_b/pc_source codes.
//  Sub-module mips_ctrl_decode: pure combinational state(+mem_ready) -> control-bundle table.
//  Top holds the state register, next-state logic and counter.
// TESTING
//  T1 reset: reset_n=0 mid-MEMRD -> all outputs 0 same cycle; after release RST, then FETCH; instr_retired=0.
//  T2 R-type: mem_ready=1, opcode=000000 -> state trace FETCH, DECODE, EXEC, ALUWB.
//     - reg_write=1 and reg_dst=1 only in ALUWB.
//     - instr_retired 0->1 after 4 cycles.
//  T3 lw with 2 wait cycles in MEMRD -> mem_read and iord held 3 cycles.
//     - MEMWB asserts reg_write and mem_to_reg.
//     - Total 7 cycles.
//  T4 sw, mem_ready=0 for 1 cycle in FETCH -> ir_write and pc_write low that cycle, high only on the ready cycle.
//     - mem_write held 1 cycle in MEMWR.
//  T5 beq then j -> pc_write_cond=1 with pc_source=1 in BRANCH; pc_write=1 with pc_source=2 in JUMP.
//     - instr_retired +2.
//  T6 opcode=111111, TRAP_EN=1 -> DECODE to FETCH; illegal_op one pulse; count unchanged.
//     - Second run with CNT_W=4 and 16 retired -> count wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : opcodes, state encoding and control codes, multicycle MIPS
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mips_ctrl_decode : state (+mem_ready in FETCH) to control-strobe table
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH2;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl : multicycle MIPS sequencer, retire counter, illegal trap
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TRAP_EN = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       state_dbg
);

  state_t           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RST;
      illegal_op_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    illegal_op_d = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = (TRAP_EN != 0);
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      // Unused encodings fall through to a clean fetch.
      default:  state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal_op_q;
  assign instr_retired = cnt_q;
  assign state_dbg     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl : random instruction stream vs per-instruction model
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic        pcw_a, pcc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a, ill_a;
  logic [1:0]  sb_a, aop_a, ps_a;
  logic [31:0] cnt_a;
  logic [3:0]  st_a;
  logic        pcw_b, pcc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, ill_b;
  logic [1:0]  sb_b, aop_b, ps_b;
  logic [3:0]  cnt_b;
  logic [3:0]  st_b;

  mips_multicycle_ctrl #(.CNT_W(32), .TRAP_EN(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_a), .pc_write_cond(pcc_a), .iord(iord_a), .mem_read(mr_a),
    .mem_write(mw_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rd_a),
    .reg_write(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a),
    .pc_source(ps_a), .illegal_op(ill_a), .instr_retired(cnt_a), .state_dbg(st_a)
  );

  mips_multicycle_ctrl #(.CNT_W(4), .TRAP_EN(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_b), .pc_write_cond(pcc_b), .iord(iord_b), .mem_read(mr_b),
    .mem_write(mw_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rd_b),
    .reg_write(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b),
    .pc_source(ps_b), .illegal_op(ill_b), .instr_retired(cnt_b), .state_dbg(st_b)
  );

  always #5 clock = ~clock;

  logic [15:0] ctl_a, ctl_b;
  assign ctl_a = {pcw_a, pcc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a, sb_a, aop_a, ps_a};
  assign ctl_b = {pcw_b, pcc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, sb_b, aop_b, ps_b};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_ill = 1'b0;

  function automatic logic [15:0] cv(input logic pcw, input logic pcc, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rd, input logic rw,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input logic [1:0] ps);
    return {pcw, pcc, io, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps};
  endfunction

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [15:0] ectl, input state_t est, input string tag);
    check(32'(ctl_a), 32'(ectl), {tag, ".ctl_a"});
    check(32'(ctl_b), 32'(ectl), {tag, ".ctl_b"});
    check(32'(st_a), 32'(est), {tag, ".state_a"});
    check(32'(st_b), 32'(est), {tag, ".state_b"});
    check(32'(ill_a), 32'(exp_ill), {tag, ".illegal_a"});
    check(32'(ill_b), 32'd0, {tag, ".illegal_b"});
    check(cnt_a, exp_cnt, {tag, ".count_a"});
    check(32'(cnt_b), 32'(exp_cnt[3:0]), {tag, ".count_b"});
  endtask

  // One clock of the instruction; retire/ill_next describe what the edge ending it does.
  task automatic cyc(input logic rdy, input logic [15:0] ectl, input state_t est,
                     input logic retire, input logic ill_next, input string tag);
    mem_ready = rdy;
    @(negedge clock);
    check_all(ectl, est, tag);
    @(posedge clock);
    #1;
    if (retire) exp_cnt = exp_cnt + 32'd1;
    exp_ill = ill_next;
  endtask

  task automatic run(input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
            (op == OP_ADDI) || (op == OP_J);
    for (int i = 0; i < fw; i++) begin
      opcode = 6'($urandom);
      cyc(1'b0, cv(0,0,0,1,0,0,0,0,0,0,2'd1,2'd0,2'd0), S_FETCH, 1'b0, 1'b0, "fetch_wait");
    end
    opcode = 6'($urandom);
    cyc(1'b1, cv(1,0,0,1,0,1,0,0,0,0,2'd1,2'd0,2'd0), S_FETCH, 1'b0, 1'b0, "fetch");
    opcode = op;
    cyc(1'($urandom), cv(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0), S_DECODE, 1'b0, !legal, "decode");
    if (op == OP_R) begin
      cyc(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0), S_EXEC, 1'b0, 1'b0, "exec");
      cyc(1'($urandom), cv(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,2'd0), S_ALUWB, 1'b1, 1'b0, "aluwb");
    end else if (op == OP_LW || op == OP_SW) begin
      cyc(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), S_MEMADR, 1'b0, 1'b0, "memadr");
      if (op == OP_LW) begin
        for (int i = 0; i < mw; i++)
          cyc(1'b0, cv(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,2'd0), S_MEMRD, 1'b0, 1'b0, "memrd_wait");
        cyc(1'b1, cv(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,2'd0), S_MEMRD, 1'b0, 1'b0, "memrd");
        cyc(1'($urandom), cv(0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0), S_MEMWB, 1'b1, 1'b0, "memwb");
      end else begin
        for (int i = 0; i < mw; i++)
          cyc(1'b0, cv(0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,2'd0), S_MEMWR, 1'b0, 1'b0, "memwr_wait");
        cyc(1'b1, cv(0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,2'd0), S_MEMWR, 1'b1, 1'b0, "memwr");
      end
    end else if (op == OP_BEQ) begin
      cyc(1'($urandom), cv(0,1,0,0,0,0,0,0,0,1,2'd0,2'd1,2'd1), S_BRANCH, 1'b1, 1'b0, "branch");
    end else if (op == OP_ADDI) begin
      cyc(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), S_ADDIEX, 1'b0, 1'b0, "addiex");
      cyc(1'($urandom), cv(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0), S_ADDIWB, 1'b1, 1'b0, "addiwb");
    end else if (op == OP_J) begin
      cyc(1'($urandom), cv(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd2), S_JUMP, 1'b1, 1'b0, "jump");
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    #3;
    check_all(16'd0, S_RST, "reset_hold");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 16'd0, S_RST, 1'b0, 1'b0, "rst_state");

    run(OP_R, 0, 0);
    run(OP_LW, 0, 2);
    run(OP_SW, 1, 0);
    run(OP_BEQ, 0, 0);
    run(OP_J, 0, 0);
    run(6'b111111, 0, 0);
    run(OP_ADDI, 0, 0);

    for (int n = 0; n < 40; n++)
      run(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));

    // Abort a load while it waits in MEMRD.
    run(OP_R, 0, 0);
    cyc(1'b1, cv(1,0,0,1,0,1,0,0,0,0,2'd1,2'd0,2'd0), S_FETCH, 1'b0, 1'b0, "pre_rst_fetch");
    opcode = OP_LW;
    cyc(1'b1, cv(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0), S_DECODE, 1'b0, 1'b0, "pre_rst_decode");
    cyc(1'b0, cv(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0), S_MEMADR, 1'b0, 1'b0, "pre_rst_memadr");
    mem_ready = 1'b0;
    #1;
    check(32'(ctl_a), 32'(cv(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,2'd0)), "pre_rst_memrd");
    reset_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    exp_ill = 1'b0;
    check_all(16'd0, S_RST, "reset_async");
    @(posedge clock);
    #1;
    check_all(16'd0, S_RST, "reset_held_edge");
    reset_n = 1'b1;
    cyc(1'b1, 16'd0, S_RST, 1'b0, 1'b0, "rst_release");

    for (int n = 0; n < 20; n++)
      run(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));
    run(6'b110011, 0, 0);
    cyc(1'b0, cv(0,0,0,1,0,0,0,0,0,0,2'd1,2'd0,2'd0), S_FETCH, 1'b0, 1'b0, "tail");
    cyc(1'b0, cv(0,0,0,1,0,0,0,0,0,0,2'd1,2'd0,2'd0), S_FETCH, 1'b0, 1'b0, "tail2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
